// File: rtl/sysid_regfile.sv
// rtl/sysid_regfile.sv - system identification / uptime register file, Avalon-MM slave
//
// Eight 32-bit words: identifier, build timestamp, a free-running uptime
// counter read as LO/HI with an atomic capture, a scratch word, a control
// word and a sticky overflow status. Reads are fully pipelined with a fixed
// latency; writes complete in the cycle they are presented.
//
// Ports:
//   clock          sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   address[2:0]   word address
//   read           read strobe, accepted every cycle it is high
//   write          write strobe, accepted every cycle it is high
//   writedata[31:0] write data
//   byteenable[3:0] write byte lanes (ignored for reads)
//   readdata[31:0] read result, zero unless readdatavalid
//   readdatavalid  one pulse per accepted read, READ_LATENCY cycles later

module sysid_regfile #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_1234,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          UPTIME_WIDTH = 64,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int HOLD_W = UPTIME_WIDTH - 32;

  localparam logic [2:0] ADDR_SYSTEM_ID = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
  localparam logic [2:0] ADDR_CONTROL   = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam logic [UPTIME_WIDTH-1:0] UPTIME_ONE = {{(UPTIME_WIDTH-1){1'b0}}, 1'b1};

  // Register state
  logic [UPTIME_WIDTH-1:0] uptime_q;
  logic [HOLD_W-1:0]       hold_q;
  logic [31:0]             scratch_q;
  logic                    enable_q;
  logic                    overflow_q;

  // Write decode
  logic wr_scratch;
  logic wr_control;
  logic wr_status;
  logic rd_uptime_lo;
  logic counter_clear;
  logic counter_wrap;
  logic overflow_clear;

  assign wr_scratch     = write && (address == ADDR_SCRATCH);
  assign wr_control     = write && (address == ADDR_CONTROL);
  assign wr_status      = write && (address == ADDR_STATUS);
  assign rd_uptime_lo   = read  && (address == ADDR_UPTIME_LO);

  // Clear lives in the same byte lane as the enable bit.
  assign counter_clear  = wr_control && byteenable[0] && writedata[1];

  // A wrap only counts when the increment actually happens; a coincident
  // clear takes the counter to zero without flagging an overflow.
  assign counter_wrap   = enable_q && !counter_clear && (&uptime_q);

  assign overflow_clear = wr_status && byteenable[0] && writedata[0];

  // Uptime counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q <= '0;
    end else if (counter_clear) begin
      uptime_q <= '0;
    end else if (enable_q) begin
      uptime_q <= uptime_q + UPTIME_ONE;
    end
  end

  // Upper counter bits are frozen by a LO read so that a following HI read
  // forms a coherent 64-bit value even if the low word rolls over meanwhile.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (rd_uptime_lo) begin
      hold_q <= uptime_q[UPTIME_WIDTH-1:32];
    end
  end

  // Scratch word with per-byte write enables
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= '0;
    end else if (wr_scratch) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          scratch_q[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  // Control: bit 0 is the stored enable; bit 1 (clear) is a pulse only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b1;
    end else if (wr_control && byteenable[0]) begin
      enable_q <= writedata[0];
    end
  end

  // Sticky overflow; a new wrap beats a simultaneous W1C.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (counter_wrap) begin
      overflow_q <= 1'b1;
    end else if (overflow_clear) begin
      overflow_q <= 1'b0;
    end
  end

  // Read mux: samples current register contents, so a read coincident with
  // a write or an increment sees the pre-update value.
  logic [31:0] hold_ext;
  logic [31:0] rd_mux;

  always_comb begin
    hold_ext = '0;
    hold_ext[HOLD_W-1:0] = hold_q;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_SYSTEM_ID: rd_mux = SYSTEM_ID;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_UPTIME_LO: rd_mux = uptime_q[31:0];
      ADDR_UPTIME_HI: rd_mux = hold_ext;
      ADDR_SCRATCH:   rd_mux = scratch_q;
      ADDR_CONTROL:   rd_mux = {31'd0, enable_q};
      ADDR_STATUS:    rd_mux = {31'd0, overflow_q};
      default:        rd_mux = '0;
    endcase
  end

  // Read pipeline. Data stages carry zero whenever their valid bit is low,
  // so the last stage drives readdata directly with no output gating.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [31:0]             pipe_data [READ_LATENCY];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= read;
      pipe_data[0]  <= read ? rd_mux : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign readdatavalid = pipe_valid[READ_LATENCY-1];
  assign readdata      = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regfile.sv
// tb/tb_sysid_regfile.sv - self-checking bench for sysid_regfile

module tb_sysid_regfile;

  localparam logic [31:0] SYS_ID = 32'h0000_1234;
  localparam logic [31:0] TSTAMP = 32'h6502_1A2B;
  localparam int          UW     = 40;
  localparam int          RL     = 3;
  localparam longint unsigned CNT_MOD = 64'd1 << UW;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  always #5 clock = ~clock;

  sysid_regfile #(
    .SYSTEM_ID   (SYS_ID),
    .TIMESTAMP   (TSTAMP),
    .UPTIME_WIDTH(UW),
    .READ_LATENCY(RL)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  longint unsigned m_cnt;
  logic [7:0]      m_hold;
  logic [31:0]     m_scr;
  bit              m_en;
  bit              m_ovf;

  typedef struct {
    int          due;
    logic [31:0] d;
    string       nm;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          chk;
    logic [31:0] ex;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got valid,data=%h required %h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return SYS_ID;
      3'd1: return TSTAMP;
      3'd2: return m_cnt[31:0];
      3'd3: return {24'd0, m_hold};
      3'd4: return m_scr;
      3'd5: return {31'd0, m_en};
      3'd6: return {31'd0, m_ovf};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_update(input bit rd, input bit wr, input logic [2:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
    bit clr, wrap, w1c;
    clr  = wr && a == 3'd5 && be[0] && wd[1];
    w1c  = wr && a == 3'd6 && be[0] && wd[0];
    wrap = 1'b0;
    if (rd && a == 3'd2) m_hold = 8'(m_cnt >> 32);
    if (clr) m_cnt = 0;
    else if (m_en) begin
      if (m_cnt == CNT_MOD - 1) wrap = 1'b1;
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end
    if (w1c) m_ovf = 1'b0;
    if (wrap) m_ovf = 1'b1;
    if (wr && a == 3'd5 && be[0]) m_en = wd[0];
    if (wr && a == 3'd4)
      for (int b = 0; b < 4; b++)
        if (be[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
  endtask

  // One bus cycle: drive, model, clock, then check the output of the next cycle.
  task automatic step(input bit rd, input bit wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input bit use_exp, input logic [31:0] ex, input string nm);
    exp_t e;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    if (rd) begin
      e.due = cyc + RL;
      e.d   = use_exp ? ex : model_read(a);
      e.nm  = nm;
      exp_q.push_back(e);
    end
    model_update(rd, wr, a, wd, be);
    @(posedge clock);
    @(negedge clock);
    cyc++;
    read = 1'b0; write = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check(e.nm, {readdatavalid, readdata}, {1'b1, e.d});
    end else begin
      check("no_valid", {readdatavalid, readdata}, 33'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 32'd0, 4'h0, 0, 32'd0, "idle");
  endtask

  task automatic rd_exp(input logic [2:0] a, input logic [31:0] ex, input string nm);
    step(1, 0, a, 32'd0, 4'h0, 1, ex, nm);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    step(0, 1, a, wd, be, 0, 32'd0, "write");
  endtask

  task automatic preset(input logic [39:0] v);
    force dut.uptime_q = v;
    #1;
    release dut.uptime_q;
    m_cnt = longint'(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_outputs", {readdatavalid, readdata}, 33'd0);
    repeat (2) @(negedge clock);
    check("reset_outputs_held", {readdatavalid, readdata}, 33'd0);
    m_cnt = 0; m_hold = 8'd0; m_scr = 32'd0; m_en = 1'b1; m_ovf = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr;
    logic [2:0] a;
    logic [31:0] wd;
    logic [3:0] be;

    tbl[0]  = '{1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 3'd4, 32'h1234_5678, 4'b0101, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0,    1'b1, 32'hFF34_FF78};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 32'h0,         4'h0,    1'b1, SYS_ID};
    tbl[4]  = '{1'b1, 1'b0, 3'd1, 32'h0,         4'h0,    1'b1, TSTAMP};
    tbl[5]  = '{1'b1, 1'b0, 3'd7, 32'h0,         4'h0,    1'b1, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'd1, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF, 4'hF,    1'b1, SYS_ID};
    tbl[8]  = '{1'b1, 1'b0, 3'd5, 32'h0,         4'h0,    1'b1, 32'h1};
    tbl[9]  = '{1'b1, 1'b0, 3'd6, 32'h0,         4'h0,    1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 3'd4, 32'hAAAA_5555, 4'hF,    1'b1, 32'hFF34_FF78};
    tbl[11] = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0,    1'b1, 32'hAAAA_5555};
    tbl[12] = '{1'b0, 1'b1, 3'd5, 32'hFFFF_FFFC, 4'hF,    1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 3'd5, 32'h0,         4'h0,    1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 3'd5, 32'h0000_0001, 4'b1110, 1'b1, 32'h0};
    tbl[15] = '{1'b1, 1'b1, 3'd5, 32'h0000_0001, 4'b0001, 1'b1, 32'h0};
    tbl[16] = '{1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF,    1'b1, 32'h0};
    tbl[17] = '{1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF,    1'b1, 32'h0};

    @(negedge clock);
    do_reset();

    // Counter starts on the first edge after release
    rd_exp(3'd2, 32'd0, "uptime_first");
    rd_exp(3'd2, 32'd1, "uptime_second");
    idle(RL);

    for (int i = 0; i < 18; i++)
      step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be,
           tbl[i].chk, tbl[i].ex, $sformatf("table_%0d", i));
    rd_exp(3'd5, 32'd1, "control_after_table");
    idle(RL);

    // LO/HI coherency across a low-word rollover
    wr_reg(3'd5, 32'd0, 4'hF);
    preset(40'h00_FFFF_FFFD);
    wr_reg(3'd5, 32'd1, 4'hF);
    rd_exp(3'd2, 32'hFFFF_FFFD, "lo_before_roll");
    idle(3);
    rd_exp(3'd3, 32'd0, "hi_held");
    rd_exp(3'd2, 32'd2, "lo_after_roll");
    rd_exp(3'd3, 32'd1, "hi_new");
    idle(RL);

    // Wrap, sticky overflow, W1C and the two coincidence rules
    preset(40'hFF_FFFF_FFFF);
    rd_exp(3'd2, 32'hFFFF_FFFF, "lo_all_ones");
    rd_exp(3'd2, 32'd0, "lo_wrapped");
    rd_exp(3'd6, 32'd1, "ovf_set");
    wr_reg(3'd6, 32'd0, 4'hF);
    rd_exp(3'd6, 32'd1, "ovf_write0_noop");
    wr_reg(3'd6, 32'd1, 4'h1);
    rd_exp(3'd6, 32'd0, "ovf_cleared");
    preset(40'hFF_FFFF_FFFF);
    wr_reg(3'd5, 32'd3, 4'hF);
    rd_exp(3'd6, 32'd0, "ovf_clear_wins");
    rd_exp(3'd2, 32'd1, "lo_after_clear");
    preset(40'hFF_FFFF_FFFF);
    wr_reg(3'd6, 32'd1, 4'h1);
    rd_exp(3'd6, 32'd1, "ovf_set_wins");
    wr_reg(3'd6, 32'd1, 4'h1);
    rd_exp(3'd6, 32'd0, "ovf_cleared_again");
    idle(RL);

    // Disabled counter holds; CONTROL=3 clears and restarts
    wr_reg(3'd5, 32'd0, 4'hF);
    preset(40'h12_3456_789A);
    rd_exp(3'd2, 32'h3456_789A, "lo_frozen_a");
    idle(9);
    rd_exp(3'd2, 32'h3456_789A, "lo_frozen_b");
    wr_reg(3'd5, 32'd3, 4'hF);
    rd_exp(3'd2, 32'd0, "lo_cleared");
    rd_exp(3'd2, 32'd1, "lo_count1");
    idle(1);
    rd_exp(3'd2, 32'd3, "lo_count3");
    rd_exp(3'd5, 32'd1, "control_bit1_reads0");
    idle(RL);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      if (a == 3'd5 && $urandom_range(0, 7) != 0) wd[1] = 1'b0;
      if (a == 3'd5 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      step(rd, wr, a, wd, be, 0, 32'd0, "random");
    end
    idle(RL);

    // Reset with reads in flight
    wr_reg(3'd4, 32'h5A5A_5A5A, 4'hF);
    wr_reg(3'd5, 32'd0, 4'hF);
    step(1, 0, 3'd4, 32'd0, 4'h0, 0, 32'd0, "inflight_a");
    step(1, 0, 3'd5, 32'd0, 4'h0, 0, 32'd0, "inflight_b");
    do_reset();
    idle(5);
    rd_exp(3'd4, 32'd0, "scratch_reset");
    rd_exp(3'd5, 32'd1, "control_reset");
    rd_exp(3'd6, 32'd0, "status_reset");
    idle(RL);

    check("queue_drained", {1'b0, 32'(exp_q.size())}, 33'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
